// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the shared single-ported memory, one transaction in flight.
// Define MEM_PORT_ARB_RR_EN for round-robin priority under contention.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [DATA_WIDTH/8-1:0] dm_be_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    output logic                    dm_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    flush_i,
    output logic                    stall_if_o,
    output logic                    stall_mem_o,
    output logic                    busy_o
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic                  r_drop;
    logic                  r_we;
    logic [BE_W-1:0]       r_be;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;

    logic                  w_pick_data;
    logic                  w_any_req;
    logic                  w_sel_we;
    logic [BE_W-1:0]       w_sel_be;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    logic                  w_issue;
    logic                  w_resp;
    logic                  w_req;
    logic                  w_we;
    logic [BE_W-1:0]       w_be;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_if_rv;
    logic                  w_dm_rv;

`ifdef MEM_PORT_ARB_RR_EN
    logic r_last;

    // Under contention the loser of the previous arbitration goes first.
    assign w_pick_data = dm_req_i & (~if_req_i | (r_last == OWN_FETCH));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last <= OWN_FETCH;
        end else if (w_issue) begin
            r_last <= w_pick_data;
        end
    end
`else
    assign w_pick_data = dm_req_i;
`endif

    assign w_any_req   = if_req_i | dm_req_i;
    assign w_sel_we    = w_pick_data ? dm_we_i : 1'b0;
    assign w_sel_be    = w_pick_data ? dm_be_i : {BE_W{1'b1}};
    assign w_sel_addr  = w_pick_data ? dm_addr_i : if_addr_i;
    assign w_sel_wdata = w_pick_data ? dm_wdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_resp  = 1'b0;
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_be    = '0;
        w_addr  = '0;
        w_wdata = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_issue = 1'b1;
                    w_req   = 1'b1;
                    w_we    = w_sel_we;
                    w_be    = w_sel_be;
                    w_addr  = w_sel_addr;
                    w_wdata = w_sel_wdata;
                    w_next  = mem_gnt_i ? S_WAIT : S_HOLD;
                end
            end
            S_HOLD: begin
                w_req   = 1'b1;
                w_we    = r_we;
                w_be    = r_be;
                w_addr  = r_addr;
                w_wdata = r_wdata;
                if (mem_gnt_i) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    w_resp = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner <= OWN_FETCH;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_issue) begin
            r_owner <= w_pick_data;
            r_we    <= w_sel_we;
            r_be    <= w_sel_be;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    // A redirected fetch must still finish on the bus; only its data is discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop <= 1'b0;
        end else if (r_state == S_IDLE || w_resp) begin
            r_drop <= 1'b0;
        end else if (flush_i && r_owner == OWN_FETCH) begin
            r_drop <= 1'b1;
        end
    end

    assign w_if_rv = w_resp & (r_owner == OWN_FETCH) & ~r_drop & ~flush_i;
    assign w_dm_rv = w_resp & (r_owner == OWN_DATA);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_if_rv) begin
                r_if_rdata <= mem_rdata_i;
            end
            if (w_dm_rv) begin
                r_dm_rdata <= mem_rdata_i;
            end
        end
    end

    assign if_rvalid_o = w_if_rv;
    assign dm_rvalid_o = w_dm_rv;
    assign if_rdata_o  = w_if_rv ? mem_rdata_i : r_if_rdata;
    assign dm_rdata_o  = w_dm_rv ? mem_rdata_i : r_dm_rdata;

    // Request-derived outputs are forced low while reset is asserted.
    assign mem_req_o   = w_req & rst_ni;
    assign mem_we_o    = w_we & rst_ni;
    assign mem_be_o    = rst_ni ? w_be : '0;
    assign mem_addr_o  = rst_ni ? w_addr : '0;
    assign mem_wdata_o = rst_ni ? w_wdata : '0;

    assign stall_if_o  = if_req_i & ~w_if_rv & rst_ni;
    assign stall_mem_o = dm_req_i & ~w_dm_rv & rst_ni;
    assign busy_o      = (r_state != S_IDLE);

endmodule
